// File: rtl/gray_counter_param.sv
// ============================================================================
// gray_counter_param
// ----------------------------------------------------------------------------
// Parametrised up/down Gray-code counter with enable, direction, synchronous
// clear/load and wrap-or-saturate behaviour at the limits.
//
// The Gray output is a flop fed from bin2gray(next_bin), so it is glitch-free
// and safe to sample from another clock domain (e.g. as a FIFO pointer). A
// registered binary view and terminal-count pulse are provided for local use.
//
// Parameters:
//   WIDTH      counter width in bits (2..16)
//   RESET_VAL  binary value loaded on reset (< 2**WIDTH)
//   WRAP       1 = wrap modulo 2**WIDTH, 0 = saturate at 0 / 2**WIDTH-1
//
// Ports:
//   clk       in   rising-edge clock
//   rstn      in   asynchronous active-low reset
//   en        in   count enable, one step per cycle
//   up_dn     in   1 = increment, 0 = decrement
//   clear     in   synchronous clear to 0 (highest priority)
//   load      in   synchronous load of load_val
//   load_val  in   [WIDTH] binary value to load
//   gray_out  out  [WIDTH] registered Gray code of the count
//   bin_out   out  [WIDTH] registered binary count
//   tc        out  registered terminal-count pulse
//   at_limit  out  combinational: count sits at the limit for up_dn
//   err       out  sticky Gray-adjacency error flag
//
// Optional build macro:
//   GRAY_CNT_CHECK_EN  when defined, an adjacency checker watches gray_out
//                      across count steps and raises err on a multi-bit
//                      change; when undefined, err is tied to 0.
// ============================================================================
module gray_counter_param #(
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0,
    parameter int WRAP      = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             tc,
    output logic             at_limit,
    output logic             err
);

    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    localparam logic [WIDTH-1:0] RST_GRAY = bin2gray(RST_BIN);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             tc_q;
    logic [WIDTH-1:0] next_bin;
    logic             tc_next;
    logic             step;
    logic             at_max;
    logic             at_min;

    assign at_max = (bin_q == MAX_VAL);
    assign at_min = (bin_q == '0);

    // Next-state selection: clear > load > en > hold. tc only ever comes from
    // a counting step, never from clear or load.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_bin = bin_q;
        tc_next  = 1'b0;
        step     = 1'b0;
        if (clear) begin
            next_bin = '0;
        end else if (load) begin
            next_bin = load_val;
        end else if (en) begin
            step = 1'b1;
            if (up_dn) begin
                if (at_max) begin
                    if (WRAP != 0) begin
                        next_bin = '0;
                        tc_next  = 1'b1;
                    end
                end else begin
                    next_bin = bin_q + ONE;
                    // Saturating mode flags the step that first arrives at MAX.
                    if (WRAP == 0 && bin_q == MAX_VAL - ONE) tc_next = 1'b1;
                end
            end else begin
                if (at_min) begin
                    if (WRAP != 0) begin
                        next_bin = MAX_VAL;
                        tc_next  = 1'b1;
                    end
                end else begin
                    next_bin = bin_q - ONE;
                    if (WRAP == 0 && bin_q == ONE) tc_next = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its inputs regardless of process ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= next_bin;
            gray_q <= bin2gray(next_bin);
            tc_q   <= tc_next;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign tc       = tc_q;
    assign at_limit = (up_dn & at_max) | (~up_dn & at_min);

`ifdef GRAY_CNT_CHECK_EN
    // Compare the current gray_out with the value before the last update when
    // that update was an en step. Zero changed bits (saturated hold) is fine;
    // more than one means the adjacency property was broken.
    logic [WIDTH-1:0] prev_gray_q;
    logic             step_q;
    logic             err_q;
    logic             adj_bad;

    assign adj_bad = step_q && ($countones(gray_q ^ prev_gray_q) > 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_gray_q <= RST_GRAY;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            prev_gray_q <= gray_q;
            step_q      <= step;
            err_q       <= err_q | adj_bad;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/gray_counter_param.md
Name: gray_counter_param

Overview:
- Parametrised up/down Gray-code counter.
- Successor to the fixed 4-bit free-running Gray counter.
- Adds WIDTH generalisation, enable, direction, synchronous load/clear, and wrap or saturate mode.
- The Gray output is registered directly, so it is glitch-free and safe to sample in another clock domain (e.g. FIFO pointers). A binary view and terminal-count flag are also provided for local logic.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..16.
- RESET_VAL, 0, binary value loaded on reset; must be < 2**WIDTH.
- WRAP, 1, 1 = wrap around at the limits; 0 = saturate at the limits.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  direction: 1 = increment, 0 = decrement.
- clear  input  1  synchronous clear to binary 0.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  binary value to load.
- gray_out  output  WIDTH  registered Gray code of the count.
- bin_out  output  WIDTH  registered binary count.
- tc  output  1  registered terminal-count pulse.
- at_limit  output  1  combinational; count sits at the limit for the current direction.
- err  output  1  sticky Gray-adjacency error flag (see Optional Feature).

Behaviour:
- Reset (rstn low, asynchronous):
  - bin_out = RESET_VAL; gray_out = RESET_VAL ^ (RESET_VAL >> 1).
  - tc = 0; err = 0.
  - Release is synchronous to clk; the first count step happens on the first rising edge with rstn high and en high.
- Next-state priority on each rising edge: clear > load > en > hold.
  - clear: bin -> 0.
  - load: bin -> load_val.
  - en with up_dn = 1: bin -> bin + 1. en with up_dn = 0: bin -> bin - 1.
  - Otherwise: hold.
- gray_out is a flop fed from bin2gray(next_bin); it is never combinational from bin_out.
  - Invariant every cycle: gray_out == bin_out ^ (bin_out >> 1).
  - Latency: one cycle from control input to both outputs.
- Limits: MAX = 2**WIDTH - 1; MIN = 0.
  - at_limit = (up_dn & bin_out == MAX) | (~up_dn & bin_out == 0).
- WRAP = 1:
  - Increment at MAX gives 0; decrement at 0 gives MAX. Modulo-2**WIDTH arithmetic.
  - tc goes high for exactly one cycle, coincident with the wrapped value appearing on the outputs.
- WRAP = 0:
  - Increment at MAX or decrement at 0 holds the value.
  - tc goes high for one cycle on the edge the count first reaches the limit by counting.
  - tc stays low while held at the limit.
- tc is never asserted by clear or load, even when the loaded value equals a limit.
- Direction change is allowed on any cycle; it takes effect on the same edge.
- Simultaneous clear and load: clear wins and load_val is ignored.
- Reset mid-count: outputs return to their reset values immediately, without waiting for clk.
- Gray adjacency: every en step changes exactly one bit of gray_out; load and clear may change any number of bits.

Optional Feature:
- Macro: GRAY_CNT_CHECK_EN.
- Defined:
  - A registered copy of the previous gray_out and a registered "last update was a step" flag are kept.
  - err sets when two consecutive gray_out values, across an en step, differ in a number of bits other than one.
  - A saturated hold (zero bits changed) is excluded from the check.
  - err is sticky until rstn is asserted; it is unaffected by clear or load.
- Not defined: err is tied to 0 and the checker logic is absent.

Test Plan:
- Reset, free-running (WIDTH=4, RESET_VAL=0, en=1, up_dn=1): gray_out sequence 0000, 0001, 0011, 0010, 0110, ... 1000, then back to 0000. tc pulses on the 0000 following 1000; err stays 0 throughout.
- Down-count wrap (WRAP=1): load_val=1 with load for one cycle, then en=1, up_dn=0 → bin_out 1, 0, 15 (gray 0001, 0000, 1000). tc pulses with bin_out=15; at_limit=1 while bin_out=0.
- Saturate (WRAP=0): load 14, then en=1, up_dn=1 → bin_out 14, 15, 15, 15. tc is a single pulse at the first 15; at_limit stays 1.
- Priority: clear=1, load=1, load_val=9, en=1 all in one cycle → bin_out=0, gray_out=0000, tc=0. The next cycle with load only gives bin_out=9, gray_out=1101.
- Async reset mid-count: assert rstn low between clock edges at bin_out=6 → outputs go to RESET_VAL immediately. Release rstn, and counting resumes from RESET_VAL on the next enabled edge.
- With GRAY_CNT_CHECK_EN defined: bench forces a two-bit gray_out jump via a hierarchical deposit on an en step → err goes to 1 and stays 1 through a later clear. Only rstn clears it.
